// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
package i2c_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StData,
      StDataAck,
      StIgnore
   } i2c_rx_state_t;

   localparam logic I2C_ACK      = 1'b0;
   localparam logic I2C_NACK     = 1'b1;
   localparam logic I2C_RW_WRITE = 1'b0;

   // Minimum SCL half-period in clk cycles; the SCL generator uses this value.
   localparam int unsigned I2C_SCL_HALF_PERIOD = 5;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizer for one bus line: reset to idle-high, history flop, rise/fall strobes.
module i2c_bus_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         hist_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   always_comb begin
      level = sync_q[SYNC_STAGES-1];
      rise  = level & ~hist_q;
      fall  = ~level & hist_q;
   end

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target receiver: matches a write address, shifts in bytes MSB-first and
// drives ACK/NACK; received bytes are handed off over a valid/ready strobe.
module i2c_target_rx
   import i2c_pkg::*;
#(
   parameter logic [6:0]  TARGET_ADDR = 7'h50,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       overflow,
   output logic       addressed
);

   logic scl_level, scl_rise, scl_fall;
   logic sda_level, sda_rise, sda_fall;
   logic start_det, stop_det;

   i2c_rx_state_t state_q, state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          sda_oe_q, sda_oe_d;
   logic          addressed_q, addressed_d;
   logic          rx_valid_q, rx_valid_d;
   logic          overflow_q, overflow_d;
   logic          ack_bit;

   i2c_bus_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_scl_sync (
      .clk     (clk),
      .rst     (rst),
      .line_in (scl_in),
      .level   (scl_level),
      .rise    (scl_rise),
      .fall    (scl_fall)
   );

   i2c_bus_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sda_sync (
      .clk     (clk),
      .rst     (rst),
      .line_in (sda_in),
      .level   (sda_level),
      .rise    (sda_rise),
      .fall    (sda_fall)
   );

   assign start_det = sda_fall & scl_level;
   assign stop_det  = sda_rise & scl_level;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         sda_oe_q    <= 1'b0;
         addressed_q <= 1'b0;
         rx_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         sda_oe_q    <= sda_oe_d;
         addressed_q <= addressed_d;
         rx_valid_q  <= rx_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      sda_oe_d    = sda_oe_q;
      addressed_d = addressed_q;
      rx_valid_d  = 1'b0;
      overflow_d  = 1'b0;
      ack_bit     = I2C_NACK;

      // Bus conditions override whatever bit processing is in progress.
      if (stop_det) begin
         state_d     = StIdle;
         sda_oe_d    = 1'b0;
         addressed_d = 1'b0;
         bit_cnt_d   = 4'd0;
      end else if (start_det) begin
         state_d     = StAddr;
         sda_oe_d    = 1'b0;
         addressed_d = 1'b0;
         bit_cnt_d   = 4'd0;
      end else begin
         case (state_q)
            StAddr, StData: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_level};
                  if (bit_cnt_q != 4'hf) begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                  if (state_q == StAddr) begin
                     if ((shift_q[7:1] == TARGET_ADDR) && (shift_q[0] == I2C_RW_WRITE)) begin
                        ack_bit = I2C_ACK;
                        state_d = StAddrAck;
                     end else begin
                        state_d = StIgnore;
                     end
                  end else begin
                     if (rx_ready) begin
                        ack_bit    = I2C_ACK;
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                     end else begin
                        overflow_d = 1'b1;
                     end
                     state_d = StDataAck;
                  end
                  sda_oe_d = (ack_bit == I2C_ACK);
               end
            end
            StAddrAck: begin
               if (scl_fall) begin
                  sda_oe_d    = 1'b0;
                  addressed_d = 1'b1;
                  bit_cnt_d   = 4'd0;
                  state_d     = StData;
               end
            end
            StDataAck: begin
               if (scl_fall) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 4'd0;
                  state_d   = StData;
               end
            end
            StIdle, StIgnore: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               state_d  = StIdle;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      sda_oe    = sda_oe_q;
      rx_data   = rx_data_q;
      rx_valid  = rx_valid_q;
      overflow  = overflow_q;
      addressed = addressed_q;
   end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: an I2C master model on a wired-AND bus, a table of
// transactions with hand-derived expectations, and randomized transactions.
module tb_i2c_target_rx;
   import i2c_pkg::*;

   localparam logic [6:0] ADDR = 7'h50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       rx_ready = 1'b1;
   logic       sda_oe, rx_valid, overflow, addressed;
   logic [7:0] rx_data;
   logic       sda_bus;

   assign sda_bus = m_sda & ~sda_oe;

   i2c_target_rx #(
      .TARGET_ADDR (ADDR),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .scl_in    (m_scl),
      .sda_in    (sda_bus),
      .sda_oe    (sda_oe),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .overflow  (overflow),
      .addressed (addressed)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]      addr;
      logic            rw;
      int              nb;
      logic [2:0][7:0] data;
      logic [2:0]      rdy;
      logic [3:0]      exp_acks;   // bit0 address, bit k+1 data byte k; 1 = ACKed
      int              exp_valid;
      int              exp_ovf;
      logic [7:0]      exp_last;
   } vec_t;

   int         n_vec = 0;
   int         n_err = 0;
   int         half  = 5;
   logic [7:0] model_last;
   vec_t       tbl [7];

   // Monitor of the local-side strobes.
   int         valid_cnt = 0;
   int         ovf_cnt   = 0;
   int         oe_cnt    = 0;
   int         proto_bad = 0;
   logic       prev_pulse = 1'b0;
   logic [7:0] got_mem [1024];

   always @(negedge clk) begin
      if (rx_valid) begin
         got_mem[valid_cnt[9:0]] <= rx_data;
         valid_cnt <= valid_cnt + 1;
      end
      if (overflow) ovf_cnt <= ovf_cnt + 1;
      if (sda_oe) oe_cnt <= oe_cnt + 1;
      if ((rx_valid && overflow) || ((rx_valid || overflow) && prev_pulse))
         proto_bad <= proto_bad + 1;
      prev_pulse <= rx_valid | overflow;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, output logic s, output logic a);
      cyc(2);
      m_sda = b;
      cyc(half - 2);
      m_scl = 1'b1;
      cyc(half / 2);
      s = sda_bus;
      a = addressed;
      cyc(half - half / 2);
      m_scl = 1'b0;
   endtask

   task automatic start_cond();
      if (m_scl) begin
         m_sda = 1'b0;
         cyc(half);
         m_scl = 1'b0;
      end else begin
         cyc(2);
         m_sda = 1'b1;
         cyc(half - 2);
         m_scl = 1'b1;
         cyc(half);
         m_sda = 1'b0;
         cyc(half);
         m_scl = 1'b0;
      end
   endtask

   task automatic stop_cond();
      cyc(2);
      m_sda = 1'b0;
      cyc(half - 2);
      m_scl = 1'b1;
      cyc(half);
      m_sda = 1'b1;
      cyc(half);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack, output logic adr_first);
      logic s, a;
      adr_first = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i], s, a);
         if (i == 7) adr_first = a;
      end
      send_bit(1'b1, s, a);
      ack = ~s;
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      int         v0, o0, e0, j;
      logic [3:0] acks, msk;
      logic [2:0] adr_seen;
      logic       ak, af;
      v0 = valid_cnt;
      o0 = ovf_cnt;
      e0 = oe_cnt;
      acks = '0;
      adr_seen = '0;
      start_cond();
      send_byte({v.addr, v.rw}, ak, af);
      acks[0] = ak;
      for (int k = 0; k < v.nb; k++) begin
         rx_ready = v.rdy[k];
         send_byte(v.data[k], ak, af);
         acks[k+1] = ak;
         adr_seen[k] = af;
      end
      rx_ready = 1'b1;
      stop_cond();
      cyc(2);
      msk = v.exp_acks[0] ? ((4'd1 << v.nb) - 4'd1) : 4'd0;
      check({tag, " acks"}, 32'(acks), 32'(v.exp_acks));
      check({tag, " rx_valid count"}, 32'(valid_cnt - v0), 32'(v.exp_valid));
      check({tag, " overflow count"}, 32'(ovf_cnt - o0), 32'(v.exp_ovf));
      check({tag, " rx_data"}, 32'(rx_data), 32'(v.exp_last));
      check({tag, " addressed during data"}, 32'(adr_seen), 32'(msk[2:0]));
      check({tag, " addressed after stop"}, 32'(addressed), 32'd0);
      check({tag, " sda_oe silent"}, 32'(oe_cnt == e0), 32'(!v.exp_acks[0]));
      j = v0;
      for (int k = 0; k < v.nb; k++) begin
         if (v.exp_acks[k+1]) begin
            check($sformatf("%s byte%0d", tag, k), 32'(got_mem[j[9:0]]), 32'(v.data[k]));
            j++;
         end
      end
   endtask

   function automatic vec_t model(input logic [6:0] addr, input logic rw, input int nb,
                                  input logic [2:0][7:0] d, input logic [2:0] rdy,
                                  input logic [7:0] last);
      vec_t v;
      logic ok;
      ok = (addr == ADDR) && !rw;
      v.addr = addr;
      v.rw = rw;
      v.nb = nb;
      v.data = d;
      v.rdy = rdy;
      v.exp_acks = '0;
      v.exp_acks[0] = ok;
      v.exp_valid = 0;
      v.exp_ovf = 0;
      v.exp_last = last;
      if (ok) begin
         for (int k = 0; k < nb; k++) begin
            if (rdy[k]) begin
               v.exp_acks[k+1] = 1'b1;
               v.exp_valid++;
               v.exp_last = d[k];
            end else begin
               v.exp_ovf++;
            end
         end
      end
      return v;
   endfunction

   initial begin
      logic       ak, af, s, a;
      int         v0;
      vec_t       v;
      logic [31:0] r1, r2;
      logic [6:0] ra;
      logic       rrw;

      tbl[0] = '{7'h50, 1'b0, 1, {8'h00, 8'h00, 8'hA5}, 3'b001, 4'b0011, 1, 0, 8'hA5};
      tbl[1] = '{7'h51, 1'b0, 1, {8'h00, 8'h00, 8'h3C}, 3'b001, 4'b0000, 0, 0, 8'hA5};
      tbl[2] = '{7'h50, 1'b1, 1, {8'h00, 8'h00, 8'h5A}, 3'b001, 4'b0000, 0, 0, 8'hA5};
      tbl[3] = '{7'h50, 1'b0, 2, {8'h00, 8'h22, 8'h11}, 3'b001, 4'b0011, 1, 1, 8'h11};
      tbl[4] = '{7'h50, 1'b0, 3, {8'hF0, 8'h0F, 8'hC3}, 3'b111, 4'b1111, 3, 0, 8'hF0};
      tbl[5] = '{7'h28, 1'b0, 1, {8'h00, 8'h00, 8'hFF}, 3'b001, 4'b0000, 0, 0, 8'hF0};
      tbl[6] = '{7'h50, 1'b0, 2, {8'h00, 8'h55, 8'hAA}, 3'b000, 4'b0001, 0, 2, 8'hF0};

      cyc(4);
      rst = 1'b0;
      check("reset sda_oe", 32'(sda_oe), 32'd0);
      check("reset rx_data", 32'(rx_data), 32'd0);
      check("reset rx_valid", 32'(rx_valid), 32'd0);
      check("reset overflow", 32'(overflow), 32'd0);
      check("reset addressed", 32'(addressed), 32'd0);
      cyc(4);

      half = I2C_SCL_HALF_PERIOD;
      for (int i = 0; i < 7; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

      // Repeated START after a partial data byte.
      v0 = valid_cnt;
      start_cond();
      send_byte({ADDR, 1'b0}, ak, af);
      check("rs first addr ack", 32'(ak), 32'd1);
      for (int i = 0; i < 4; i++) send_bit(i[0], s, a);
      check("rs addressed before", 32'(addressed), 32'd1);
      start_cond();
      cyc(2);
      check("rs addressed dropped", 32'(addressed), 32'd0);
      check("rs sda released", 32'(sda_oe), 32'd0);
      send_byte({ADDR, 1'b0}, ak, af);
      check("rs re-ack", 32'(ak), 32'd1);
      send_byte(8'h7E, ak, af);
      check("rs data ack", 32'(ak), 32'd1);
      check("rs addressed in data", 32'(af), 32'd1);
      stop_cond();
      cyc(2);
      check("rs rx_valid count", 32'(valid_cnt - v0), 32'd1);
      check("rs rx_data", 32'(rx_data), 32'h7E);

      // Reset after bit 5 of a data byte.
      start_cond();
      send_byte({ADDR, 1'b0}, ak, af);
      for (int i = 0; i < 5; i++) send_bit(1'b1, s, a);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid rst sda_oe", 32'(sda_oe), 32'd0);
      check("mid rst rx_data", 32'(rx_data), 32'd0);
      check("mid rst rx_valid", 32'(rx_valid), 32'd0);
      check("mid rst overflow", 32'(overflow), 32'd0);
      check("mid rst addressed", 32'(addressed), 32'd0);
      stop_cond();
      v = model(ADDR, 1'b0, 1, {8'h00, 8'h00, 8'h9C}, 3'b001, 8'h00);
      apply_vec(v, "post-rst");
      model_last = v.exp_last;

      for (int i = 0; i < 30; i++) begin
         r1 = $urandom;
         r2 = $urandom;
         half = int'(I2C_SCL_HALF_PERIOD) + int'($urandom_range(0, 3));
         ra = ($urandom_range(0, 3) != 0) ? ADDR : r2[14:8];
         rrw = ($urandom_range(0, 3) == 0);
         v = model(ra, rrw, int'($urandom_range(1, 3)), r1[23:0], r2[2:0] | r2[5:3],
                   model_last);
         apply_vec(v, $sformatf("rnd%0d", i));
         model_last = v.exp_last;
      end

      check("pulse exclusivity", 32'(proto_bad), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
